est_sync_dualrail_fifo: RTL and testbench

Clocked receiver for a 4-phase dual-rail asynchronous pipeline. It completion-detects a full dual-rail codeword of parametrised width, synchronises it into the `clk` domain and stores it in a DEPTH-entry FIFO. It drives the return-to-zero acknowledge back to the asynchronous stage and presents the data on a valid/ready interface. It sits at the boundary where the self-timed datapath hands results to clocked logic, and applies backpressure by withholding the acknowledge.

---
 rtl/est_pkg.sv | 24 ++
 rtl/est_sync_fifo.sv | 55 +++++
 rtl/est_sync_dualrail_fifo.sv | 125 ++++++++++++
 tb/tb_est_sync_dualrail_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/est_pkg.sv
// Shared types and helpers for the dual-rail receiver: FSM state, sync-depth floor, rail decoder.
// Combinational only; no latency or backpressure of its own.
package est_pkg;

  typedef enum logic {
    EST_IDLE = 1'b0,
    EST_ACKD = 1'b1
  } est_state_t;

  localparam int EST_SYNC_STAGES_MIN = 2;
  localparam int EST_MAX_WIDTH       = 64;

  // Bit i is the true rail of pair i; an illegal both-high pair decodes to 0.
  function automatic logic [EST_MAX_WIDTH-1:0] est_dr_decode(
    input logic [2*EST_MAX_WIDTH-1:0] rails
  );
    logic [EST_MAX_WIDTH-1:0] v;
    for (int i = 0; i < EST_MAX_WIDTH; i++) begin
      v[i] = rails[2*i+1] & ~rails[2*i];
    end
    return v;
  endfunction

endpackage

// File: rtl/est_sync_fifo.sv
// Register FIFO, WIDTH x DEPTH; push/level visible one edge later, head is combinational.
// Push ignored when full, pop ignored when empty; caller gates push with full.
module est_sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push != do_pop) begin
        level <= do_push ? level + LW'(1) : level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/est_sync_dualrail_fifo.sv
// Dual-rail 4-phase receiver: push + ack rise one edge after a synchronised complete codeword; ack withheld while full.
// Optional sticky illegal-codeword flag built only when EST_SYNC_DUALRAIL_ERR_EN is defined.
module est_sync_dualrail_fifo
  import est_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2*WIDTH-1:0]     data_in,
  output logic                   ack,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err
);

  localparam int NSTG = (SYNC_STAGES < EST_SYNC_STAGES_MIN) ? EST_SYNC_STAGES_MIN : SYNC_STAGES;

  logic [2*WIDTH-1:0] sync_q [NSTG];
  logic [2*WIDTH-1:0] srail;
  logic [WIDTH-1:0]   rail_t;
  logic [WIDTH-1:0]   rail_f;
  logic [WIDTH-1:0]   dec_val;
  logic               complete;
  logic               spacer;
  logic               push;
  logic               fifo_full;
  logic               fifo_empty;
  est_state_t         state_q;
  est_state_t         state_d;

  // Every rail gets its own flop chain; rail monotonicity makes per-rail skew harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTG; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= data_in;
      for (int i = 1; i < NSTG; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign srail = sync_q[NSTG-1];

  always_comb begin
    rail_t = '0;
    rail_f = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rail_t[i] = srail[2*i+1];
      rail_f[i] = srail[2*i];
    end
  end

  // A both-high pair fails the XOR, so an illegal word is never complete.
  assign complete = &(rail_t ^ rail_f);
  assign spacer   = ~|srail;
  assign dec_val  = WIDTH'(est_dr_decode((2*EST_MAX_WIDTH)'(srail)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EST_IDLE: if (complete && !fifo_full) state_d = EST_ACKD;
      EST_ACKD: if (spacer)                 state_d = EST_IDLE;
      default:                              state_d = EST_IDLE;
    endcase
  end

  always_comb begin
    ack  = 1'b0;
    push = 1'b0;
    case (state_q)
      EST_IDLE: push = complete & ~fifo_full;
      EST_ACKD: ack  = 1'b1;
      default:  ack  = 1'b0;
    endcase
  end

  est_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (dec_val),
    .pop       (out_valid & out_ready),
    .pop_data  (out_data),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = ~fifo_empty;

`ifdef EST_SYNC_DUALRAIL_ERR_EN
  logic bad_pair;
  assign bad_pair = |(rail_t & rail_f);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (bad_pair) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_est_sync_dualrail_fifo.sv
// Bench for est_sync_dualrail_fifo: queue-based reference model compared every negedge, plus directed literal checks.
module tb_est_sync_dualrail_fifo;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int SS = 2;
`ifdef EST_SYNC_DUALRAIL_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [2*W-1:0]      data_in = '0;
  logic                ack;
  logic [W-1:0]        out_data;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [$clog2(D):0]  level;
  logic                err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  est_sync_dualrail_fifo #(
    .WIDTH       (W),
    .DEPTH       (D),
    .SYNC_STAGES (SS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .err       (err)
  );

  // Reference model: rails seen by the receiver are data_in delayed by SS edges.
  logic [2*W-1:0] dq[$];
  logic [W-1:0]   mq[$];
  logic           m_ack = 1'b0;
  logic           m_err = 1'b0;

  function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq = {};
      for (int i = 0; i < SS; i++) dq.push_back('0);
      mq = {};
      m_ack = 1'b0;
      m_err = 1'b0;
    end else begin
      logic [2*W-1:0] s;
      logic [W-1:0]   v;
      bit             cmp;
      bit             bad;
      bit             pop;
      bit             push;
      s   = dq[SS-1];
      cmp = 1'b1;
      bad = 1'b0;
      v   = '0;
      for (int i = 0; i < W; i++) begin
        if (s[2*i+1] == s[2*i]) cmp = 1'b0;
        if (s[2*i+1] && s[2*i]) bad = 1'b1;
        v[i] = s[2*i+1];
      end
      pop  = (mq.size() != 0) && out_ready;
      push = !m_ack && cmp && (mq.size() < D);
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(v);
        m_ack = 1'b1;
      end else if (m_ack && (s == '0)) begin
        m_ack = 1'b0;
      end
      if (ERR_EN && bad) m_err = 1'b1;
      dq.push_front(data_in);
      void'(dq.pop_back());
    end
  end

  always @(negedge clk) begin
    chk("m_ack", 32'(ack), 32'(m_ack));
    chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("m_level", 32'(level), mq.size());
    chk("m_err", 32'(err), 32'(m_err));
    if (mq.size() != 0) chk("m_out_data", 32'(out_data), 32'(mq[0]));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input logic v, input string name);
    int n = 0;
    while (ack !== v && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(ack), 32'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] full_w;
    logic [2*W-1:0] part;
    int n;

    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("rst_ack", 32'(ack), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_err", 32'(err), 0);
      tick(1);
    end

    // Single word 0xA with the consumer ready.
    out_ready = 1'b1;
    data_in = 8'b10_01_10_01;
    wait_ack(1'b1, "a_ack_rise");
    chk("a_valid", 32'(out_valid), 1);
    chk("a_data", 32'(out_data), 32'hA);
    data_in = '0;
    wait_ack(1'b0, "a_ack_fall");
    chk("a_level_empty", 32'(level), 0);

    // Fill to DEPTH, fifth word is held off until one pop.
    out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      data_in = enc(W'(v));
      wait_ack(1'b1, "fill_ack_rise");
      data_in = '0;
      wait_ack(1'b0, "fill_ack_fall");
    end
    chk("fill_level4", 32'(level), 4);
    data_in = enc(4'd5);
    tick(10);
    chk("full_no_ack", 32'(ack), 0);
    chk("full_level", 32'(level), 4);
    chk("full_head", 32'(out_data), 1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("pop_level3", 32'(level), 3);
    chk("pop_ack_still_low", 32'(ack), 0);
    tick(1);
    chk("late_ack", 32'(ack), 1);
    chk("late_level4", 32'(level), 4);
    data_in = '0;
    wait_ack(1'b0, "late_ack_fall");
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", 32'(out_valid), 1);
      chk("drain_order", 32'(out_data), 32'(k + 2));
      tick(1);
    end
    out_ready = 1'b0;
    chk("drain_level0", 32'(level), 0);
    chk("drain_valid0", 32'(out_valid), 0);

    // Pairs settle one per cycle; latency counted from the last pair.
    full_w = enc(4'd6);
    part = '0;
    for (int i = 0; i < W; i++) begin
      part[2*i +: 2] = full_w[2*i +: 2];
      data_in = part;
      if (i < W - 1) tick(1);
    end
    n = 0;
    do begin
      tick(1);
      n++;
    end while (ack !== 1'b1 && n < 20);
    chk("stagger_latency", 32'(n), 32'(SS + 1));
    chk("stagger_data", 32'(out_data), 6);
    chk("stagger_level", 32'(level), 1);
    data_in = '0;
    wait_ack(1'b0, "stagger_ack_fall");

    // Reset in ACKD with two entries; held word is re-accepted afterwards.
    data_in = enc(4'd3);
    wait_ack(1'b1, "pre_rst_ack");
    chk("pre_rst_level", 32'(level), 2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ack", 32'(ack), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_level", 32'(level), 0);
    tick(2);
    rst_n = 1'b1;
    wait_ack(1'b1, "reaccept_ack");
    chk("reaccept_data", 32'(out_data), 3);
    chk("reaccept_level", 32'(level), 1);
    data_in = '0;
    wait_ack(1'b0, "reaccept_ack_fall");
    out_ready = 1'b1;
    tick(2);
    out_ready = 1'b0;
    chk("reaccept_drained", 32'(level), 0);

    // Illegal both-high pair: never pushed; flags only when the check is built.
    data_in = 8'b11_01_01_01;
    tick(8);
    chk("illegal_no_ack", 32'(ack), 0);
    chk("illegal_level", 32'(level), 0);
    chk("illegal_err", 32'(err), 32'(ERR_EN));
    data_in = '0;
    tick(5);
    chk("illegal_err_sticky", 32'(err), 32'(ERR_EN));
    rst_n = 1'b0;
    tick(1);
    chk("err_cleared", 32'(err), 0);
    rst_n = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
